// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: state encoding,
// default operand width and the flag-packing helper used when a compare completes.
package serial_cmp_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Packs the final decision as {agtb, aeqb, altb}; undecided after all bits means equal.
   function automatic logic [2:0] flags_from(input logic decided, input logic gt,
                                              input logic lt);
      return {gt, ~decided, lt};
   endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// Request/result bundle of the serial comparator: operands plus start in,
// ready/done handshake and the three magnitude flags out.
interface serial_mag_comp_if
   import serial_cmp_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic             agtb;
   logic             aeqb;
   logic             altb;

   modport master (
      output start, a, b,
      input  ready, done, agtb, aeqb, altb
   );

   modport slave (
      input  start, a, b,
      output ready, done, agtb, aeqb, altb
   );

endinterface

// File: rtl/serial_cmp_cell.sv
// Combinational per-bit decision cell: the first differing bit pair (MSB first)
// latches the outcome; once decided, later bits pass the previous decision through.
module serial_cmp_cell (
   input  logic a_bit,
   input  logic b_bit,
   input  logic decided_in,
   input  logic gt_in,
   input  logic lt_in,
   output logic decided_out,
   output logic gt_out,
   output logic lt_out
);

   always_comb begin
      decided_out = decided_in | (a_bit ^ b_bit);
      gt_out      = gt_in;
      lt_out      = lt_in;
      if (!decided_in) begin
         gt_out = a_bit & ~b_bit;
         lt_out = ~a_bit & b_bit;
      end
   end

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator, one bit pair per clock, MSB first.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_mag_comp
   import serial_cmp_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   serial_mag_comp_if.slave    bus
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_s;
   logic [WIDTH-1:0]   r_b_s;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_decided;
   logic               r_gt;
   logic               r_lt;
   logic               r_ready;
   logic               r_done;
   logic               r_agtb;
   logic               r_aeqb;
   logic               r_altb;

   logic               w_decided;
   logic               w_gt;
   logic               w_lt;
   logic               w_last;
   logic               w_finish;
   logic               w_accept;

   serial_cmp_cell u_cell (
      .a_bit       (r_a_s[WIDTH-1]),
      .b_bit       (r_b_s[WIDTH-1]),
      .decided_in  (r_decided),
      .gt_in       (r_gt),
      .lt_in       (r_lt),
      .decided_out (w_decided),
      .gt_out      (w_gt),
      .lt_out      (w_lt)
   );

   assign w_last   = (r_cnt == CNT_W'(1));
   // ready is high exactly in IDLE and DONE, so it doubles as the accept qualifier.
   assign w_accept = r_ready & bus.start;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign w_finish = w_last | (w_decided & ~r_decided);
`else
   assign w_finish = w_last;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_a_s     <= '0;
         r_b_s     <= '0;
         r_cnt     <= '0;
         r_decided <= 1'b0;
         r_gt      <= 1'b0;
         r_lt      <= 1'b0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_agtb    <= 1'b0;
         r_aeqb    <= 1'b0;
         r_altb    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_state   <= ST_SHIFT;
            r_a_s     <= bus.a;
            r_b_s     <= bus.b;
            r_cnt     <= CNT_W'(WIDTH);
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_ready   <= 1'b0;
            r_agtb    <= 1'b0;
            r_aeqb    <= 1'b0;
            r_altb    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_ready <= 1'b1;
               end
               ST_SHIFT: begin
                  r_decided <= w_decided;
                  r_gt      <= w_gt;
                  r_lt      <= w_lt;
                  r_a_s     <= {r_a_s[WIDTH-2:0], 1'b0};
                  r_b_s     <= {r_b_s[WIDTH-2:0], 1'b0};
                  r_cnt     <= r_cnt - CNT_W'(1);
                  if (w_finish) begin
                     r_state <= ST_DONE;
                     r_ready <= 1'b1;
                     r_done  <= 1'b1;
                     {r_agtb, r_aeqb, r_altb} <= flags_from(w_decided, w_gt, w_lt);
                  end
               end
               ST_DONE: begin
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.ready = r_ready;
   assign bus.done  = r_done;
   assign bus.agtb  = r_agtb;
   assign bus.aeqb  = r_aeqb;
   assign bus.altb  = r_altb;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed plus randomized bench for serial_mag_comp, checked against an
// arithmetic reference (operand compare, first-difference latency).
module tb_serial_mag_comp;

   localparam int unsigned W     = 4;
   localparam int unsigned LIMIT = 4 * W + 8;
   localparam int unsigned NRAND = 24;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [W-1:0] exp_a;
   logic [W-1:0] exp_b;

   serial_mag_comp_if #(.WIDTH(W)) bus_if ();

   serial_mag_comp #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      logic [W-1:0] d;
      d = a ^ b;
      for (int i = W - 1; i >= 0; i--) begin
         if (d[i]) return (W - i) + 1;
      end
`endif
      return W + 1;
   endfunction

   function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b);
      return {a > b, a == b, a < b};
   endfunction

   function automatic logic [2:0] obs_flags();
      return {bus_if.agtb, bus_if.aeqb, bus_if.altb};
   endfunction

   // Called at a negedge while the DUT is ready; the start is sampled at the next edge.
   task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      chk({tag, " ready before start"}, 32'(bus_if.ready), 32'd1);
      bus_if.start = 1'b1;
      bus_if.a     = a;
      bus_if.b     = b;
      exp_a        = a;
      exp_b        = b;
   endtask

   task automatic finish_op(input string tag, input bit chain, input logic [W-1:0] na,
                            input logic [W-1:0] nb, input bit noise);
      int         t;
      int         lat;
      bit         seen;
      logic [2:0] ef;
      t    = 0;
      seen = 1'b0;
      lat  = ref_latency(exp_a, exp_b);
      ef   = ref_flags(exp_a, exp_b);
      while (t < LIMIT) begin
         @(negedge clk);
         t++;
         if (bus_if.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (t == 1) begin
            chk({tag, " busy ready"}, 32'(bus_if.ready), 32'd0);
            chk({tag, " busy flags"}, 32'(obs_flags()), 32'd0);
         end
         // Starts and operand changes while busy must be ignored.
         bus_if.start = noise && (t < lat) && ((t == 1) || ($urandom_range(0, 1) == 1));
         if (noise) begin
            bus_if.a = W'($urandom);
            bus_if.b = W'($urandom);
         end
      end
      chk({tag, " done seen"}, 32'(seen), 32'd1);
      chk({tag, " latency"}, 32'(t), 32'(lat));
      chk({tag, " flags"}, 32'(obs_flags()), 32'(ef));
      chk({tag, " ready at done"}, 32'(bus_if.ready), 32'd1);
      if (chain) begin
         bus_if.start = 1'b1;
         bus_if.a     = na;
         bus_if.b     = nb;
         exp_a        = na;
         exp_b        = nb;
      end else begin
         bus_if.start = 1'b0;
         @(negedge clk);
         chk({tag, " done one cycle"}, 32'(bus_if.done), 32'd0);
         chk({tag, " flags held"}, 32'(obs_flags()), 32'(ef));
         chk({tag, " ready idle"}, 32'(bus_if.ready), 32'd1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ndone;
      bit         chain;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      reset        = 1'b1;
      bus_if.start = 1'b0;
      bus_if.a     = '0;
      bus_if.b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("reset ready", 32'(bus_if.ready), 32'd1);
      chk("reset done", 32'(bus_if.done), 32'd0);
      chk("reset flags", 32'(obs_flags()), 32'd0);

      start_op("gt", 4'b1010, 4'b0111);
      finish_op("gt", 1'b0, '0, '0, 1'b0);
      start_op("eq", 4'b0110, 4'b0110);
      finish_op("eq", 1'b0, '0, '0, 1'b0);
      start_op("lt_lsb", 4'b0010, 4'b0011);
      finish_op("lt_lsb", 1'b0, '0, '0, 1'b0);
      start_op("zero", 4'b0000, 4'b0000);
      finish_op("zero", 1'b0, '0, '0, 1'b0);
      start_op("ones", 4'b1111, 4'b0000);
      finish_op("ones", 1'b0, '0, '0, 1'b0);

      start_op("b2b1", 4'd9, 4'd3);
      finish_op("b2b1", 1'b1, 4'd3, 4'd9, 1'b0);
      finish_op("b2b2", 1'b0, '0, '0, 1'b0);

      start_op("ignore", 4'b0101, 4'b1100);
      finish_op("ignore", 1'b0, '0, '0, 1'b1);

      // Abort two cycles into SHIFT; equal operands keep it busy in both builds.
      start_op("abort", 4'b0110, 4'b0110);
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort ready", 32'(bus_if.ready), 32'd1);
      chk("abort flags", 32'(obs_flags()), 32'd0);
      ndone = (bus_if.done === 1'b1) ? 1 : 0;
      repeat (LIMIT) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) ndone++;
      end
      chk("abort no done", 32'(ndone), 32'd0);
      start_op("after_abort", 4'd15, 4'd0);
      finish_op("after_abort", 1'b0, '0, '0, 1'b0);

      ra = W'($urandom);
      rb = W'($urandom);
      start_op("rnd", ra, rb);
      for (int i = 0; i < NRAND; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         chain = (i < NRAND - 1) && ($urandom_range(0, 1) == 1);
         finish_op("rnd", chain, ra, rb, 1'b1);
         if (!chain && (i < NRAND - 1)) start_op("rnd", ra, rb);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Bit-serial magnitude comparator: captures two WIDTH-bit unsigned operands on a start handshake.
- Walks them MSB-first, one bit pair per clock, to produce agtb/aeqb/altb flags.
- Sequential, low-area counterpart to the parallel combinational comparator family in the comparator library.
- Used where operands arrive infrequently and a multi-cycle result is acceptable.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a compare; sampled only when ready=1
- a  input  WIDTH  operand A, unsigned; sampled with start
- b  input  WIDTH  operand B, unsigned; sampled with start
- ready  output  1  high in IDLE and DONE; block accepts start
- done  output  1  one-cycle pulse when result flags become valid
- agtb  output  1  A > B, held until next accepted start
- aeqb  output  1  A == B, held until next accepted start
- altb  output  1  A < B, held until next accepted start

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - Reset takes effect on the rising clk edge with reset=1.
  - State=IDLE, ready=1, done=0, agtb=0, aeqb=0, altb=0, shift registers and counter cleared.
- Reset mid-SHIFT aborts the compare; no done pulse is issued for the aborted operation.
- States:
  - IDLE: ready=1. On start=1, load a/b into shift regs, clear the decided/gt/lt internals, counter=WIDTH, clear all three flags, go to SHIFT.
  - SHIFT: ready=0. Each cycle, compare shift-reg MSBs a_s[W-1], b_s[W-1].
    - If not yet decided and the bits differ: decided<=1, gt<=a_bit, lt<=b_bit.
    - Shift both regs left by 1 and decrement the counter.
    - When the counter reaches 1 in this cycle, go to DONE.
    - start is ignored while in SHIFT.
  - DONE: done=1 for exactly this cycle; flags are registered and valid.
    - aeqb = ~decided, agtb = gt, altb = lt.
    - ready=1: a start in this cycle is accepted (back-to-back) and goes to SHIFT; otherwise go to IDLE.
- Latency: start accepted at edge k; SHIFT occupies WIDTH cycles; done is high in the cycle following edge k+WIDTH.
  - Start-to-done is WIDTH+1 cycles.
  - Throughput is one compare per WIDTH+1 cycles.
- Flags are one-hot after the first done: exactly one of agtb/aeqb/altb is 1.
  - All three are 0 from reset or from an accepted start until done.
- Once decided=1, later bits never change gt/lt (the first MSB difference wins).
- Boundaries:
  - a=b=0 gives aeqb.
  - a=all-ones, b=0 gives agtb.
  - Operand inputs changing during SHIFT have no effect.

Optional Feature:
- SERIAL_CMP_EARLY_EXIT_EN, defined:
  - In SHIFT, the cycle decided would become 1 transitions directly to DONE.
  - Latency becomes (position of the first differing bit counted from the MSB, 1-based) + 1 cycles.
  - Equal operands still take WIDTH+1.
- Not defined: fixed WIDTH+1 latency, as specified above.

Decomposition:
- Shared package/header serial_cmp_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10.
  - Default WIDTH constant.
- One sub-module, serial_cmp_cell: the combinational per-bit decision cell.
  - Inputs: a_bit, b_bit, decided_in, gt_in, lt_in.
  - Outputs: decided_out, gt_out, lt_out.
  - The top module holds the FSM, counter and shift registers.

Test Plan:
- WIDTH=4, reset, then start with a=4'b1010, b=4'b0111:
  - done pulses 5 cycles after start.
  - agtb=1, aeqb=0, altb=0.
  - Early-exit build: done after 2 cycles.
- a=4'b0110, b=4'b0110: aeqb=1 after 5 cycles in both builds; agtb=altb=0.
- a=4'b0010, b=4'b0011: altb=1; early-exit done after 5 cycles (the LSB decides).
- Back-to-back: start held high through DONE with a=9, b=3 then a=3, b=9:
  - Second op accepted in the DONE cycle.
  - Results agtb then altb, with done pulses 5 cycles apart.
- Reset asserted 2 cycles into SHIFT:
  - Next cycle shows ready=1 and flags 0.
  - No done pulse.
  - A subsequent compare of a=15, b=0 gives agtb.
- start pulsed during SHIFT with different operands: ignored; the result reflects the original operands.
